aes192_iter_ctrl: RTL

//  Iterative AES-192 encrypt engine: one shared full-round datapath (sub/shift/mix/ark) reused 11x, plus final round.

---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_final_round.sv | 22 ++
 rtl/aes192_iter_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative AES-192 encrypt engine.
// Holds the block width, round count and controller state encoding.
// Holds the round-transform helpers used by the full-round datapath and
// the final-round datapath: sub_bytes, shift_rows and mix_columns.
// A 128-bit block is byte 0 in [127:120]. Bytes are column-major, so byte i
// sits at row i%4, column i/4.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int NR_192    = 12;

  typedef enum logic [2:0] {IDLE, ARK0, ROUND, FINAL, DONE} ctrl_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // The S-box is computed instead of stored. The multiplicative inverse is
  // x^254 = x^2 * x^4 * ... * x^128, so 0 maps to 0 with no special case.
  // The affine transform follows the inverse.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_final_round.sv
// Final AES round datapath. It applies SubBytes, then ShiftRows, then
// AddRoundKey. The last round has no MixColumns.
// Ports:
//   st_i : current cipher state
//   rk_i : last round key
//   st_o : ciphertext (combinational)
module aes_final_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] st_i,
  input  logic [AES_BLK_W-1:0] rk_i,
  output logic [AES_BLK_W-1:0] st_o
);

  logic [AES_BLK_W-1:0] sub_q_unused_free;
  logic [AES_BLK_W-1:0] shifted;

  assign sub_q_unused_free = sub_bytes(st_i);
  assign shifted           = shift_rows(sub_q_unused_free);
  assign st_o              = shifted ^ rk_i;

endmodule

// File: rtl/aes192_iter_ctrl.sv
// Iterative AES-192 encrypt engine. One full-round datapath is reused for
// rounds 1..NR-1. A separate final-round path handles round NR. Round keys
// are read from an external expanded-key store.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   key_valid            : key store holds a complete schedule (level)
//   in_valid/in_ready    : plaintext handshake; in_data byte 0 in [127:120]
//   rk_addr              : registered round-key address
//   rk_data              : round key for the current rk_addr
//   out_valid/out_ready  : ciphertext handshake; out_data is the state register
//   busy                 : high whenever the controller is not IDLE
// Timing: a block accepted in cycle T presents out_valid from cycle T+14.
module aes192_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_192,
  parameter int RK_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [RK_AW-1:0]     rk_addr,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  localparam logic [RK_AW-1:0] LAST_FULL_RND = RK_AW'(NR - 1);

  ctrl_state_e          state_q;
  logic [AES_BLK_W-1:0] st_q, st_d;
  logic [AES_BLK_W-1:0] full_rnd, final_rnd;
  logic [RK_AW-1:0]     rnd_q, rk_addr_q;

  assign full_rnd = mix_columns(shift_rows(sub_bytes(st_q))) ^ rk_data;

  aes_final_round u_final (
    .st_i (st_q),
    .rk_i (rk_data),
    .st_o (final_rnd)
  );

  // State mux: load plaintext, apply whitening key, full round, or final round.
  always_comb begin
    st_d = st_q;
    case (state_q)
      IDLE:    if (in_valid && key_valid) st_d = in_data;
      ARK0:    st_d = st_q ^ rk_data;
      ROUND:   st_d = full_rnd;
      FINAL:   st_d = final_rnd;
      default: st_d = st_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      rnd_q     <= '0;
      rk_addr_q <= '0;
    end else begin
      st_q <= st_d;
      case (state_q)
        IDLE: begin
          if (in_valid && key_valid) begin
            rk_addr_q <= '0;
            rnd_q     <= '0;
            state_q   <= ARK0;
          end
        end
        ARK0: begin
          rk_addr_q <= RK_AW'(1);
          rnd_q     <= RK_AW'(1);
          state_q   <= ROUND;
        end
        ROUND: begin
          // rk_addr always leads rnd by the key needed next cycle. After the
          // last full round it lands on NR and stays there through DONE.
          rk_addr_q <= rnd_q + RK_AW'(1);
          rnd_q     <= rnd_q + RK_AW'(1);
          if (rnd_q == LAST_FULL_RND) state_q <= FINAL;
        end
        FINAL: state_q <= DONE;
        DONE:  if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so a block offered during reset is never seen as accepted.
  assign in_ready  = (state_q == IDLE) && key_valid && !rst;
  assign rk_addr   = rk_addr_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = st_q;
  assign busy      = (state_q != IDLE);

endmodule
